// File: rtl/lobinho_pkg.sv
// lobinho_pkg: state codes, debug error code and default parameters for the werewolf game controller.
package lobinho_pkg;
    localparam int N_JOG_DEF  = 5;
    localparam int W_IDX_DEF  = 4;
    localparam int T_DISC_DEF = 200;
    localparam logic [4:0] DB_ERRO = 5'd31;
    typedef enum logic [4:0] {
        INICIAL       = 5'd0,
        RESETA        = 5'd1,
        PREPARA_JOGO  = 5'd2,
        ARMAZENA      = 5'd3,
        PREPARA_NOITE = 5'd4,
        CHECAR_VIVO   = 5'd5,
        DELAY_NOITE   = 5'd6,
        TURNO_NOITE   = 5'd7,
        PROXIMO       = 5'd8,
        FIM_NOITE     = 5'd9,
        ANUNCIAR      = 5'd10,
        CHECA_NOITE   = 5'd11,
        DIA_DISCUSSAO = 5'd12,
        DIA_VOTO      = 5'd13,
        PROCESSA_VOTO = 5'd14,
        CHECA_DIA     = 5'd15,
        LOBO_GANHOU   = 5'd16,
        LOBO_PERDEU   = 5'd17
    } estado_t;
endpackage

// File: rtl/contagem_vivos.sv
// contagem_vivos: counts live wolves and villagers and decides the game outcome.
module contagem_vivos #(
    parameter int N_JOG = 5
) (
    input  logic [N_JOG-1:0] vivos,
    input  logic [N_JOG-1:0] lobo_mask,
    output logic             lobo_ganhou,
    output logic             lobo_perdeu
);
    logic [4:0] n_lobo, n_ald;
    always_comb begin
        n_lobo = '0;
        n_ald  = '0;
        for (int i = 0; i < N_JOG; i++) begin
            n_lobo = n_lobo + {4'b0, vivos[i] & lobo_mask[i]};
            n_ald  = n_ald  + {4'b0, vivos[i] & ~lobo_mask[i]};
        end
    end
    assign lobo_perdeu = n_lobo == '0;
    assign lobo_ganhou = !lobo_perdeu && n_lobo >= n_ald;
endmodule

// File: rtl/controle_partida.sv
// controle_partida: game-flow FSM for a werewolf party game (night turns, kills, day vote, win check).
module controle_partida
    import lobinho_pkg::*;
#(
    parameter int N_JOG  = N_JOG_DEF,
    parameter int W_IDX  = W_IDX_DEF,
    parameter int T_DISC = T_DISC_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             jogar,
    input  logic             passa,
    input  logic             jogou,
    input  logic             votou,
    input  logic [N_JOG-1:0] lobo_mask,
    input  logic [W_IDX-1:0] alvo,
    output logic [W_IDX-1:0] jogador_atual,
    output logic [N_JOG-1:0] vivos,
    output logic             morte_noite,
    output logic [W_IDX-1:0] idx_morte,
    output logic             mostra_classe,
    output logic             voto,
    output logic             inc_seed,
    output logic             e_seed_reg,
    output logic             rst_global,
    output logic [4:0]       db_estado
);
    localparam int NP  = 2 ** W_IDX;
    localparam int W_T = T_DISC > 1 ? $clog2(T_DISC) : 1;

    estado_t          estado;
    logic [N_JOG-1:0] lobos;
    logic [W_IDX-1:0] alvo_pend, alvo_voto;
    logic             pend_valido;
    logic [W_T-1:0]   timer;
    logic             lobo_ganhou, lobo_perdeu;

    // Padding to a power of two lets any index (even >= N_JOG) read a dead, non-wolf slot.
    logic [NP-1:0] vivos_x, lobos_x, um_pend, um_voto;
    assign vivos_x = NP'(vivos);
    assign lobos_x = NP'(lobos);
    assign um_pend = NP'(1) << alvo_pend;
    assign um_voto = NP'(1) << alvo_voto;

    logic ultimo, mata;
    assign ultimo = jogador_atual == W_IDX'(N_JOG - 1);
    assign mata   = pend_valido && vivos_x[alvo_pend] && !lobos_x[alvo_pend];

    contagem_vivos #(.N_JOG(N_JOG)) u_contagem (
        .vivos      (vivos),
        .lobo_mask  (lobos),
        .lobo_ganhou(lobo_ganhou),
        .lobo_perdeu(lobo_perdeu)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= INICIAL;
            jogador_atual <= '0;
            vivos         <= '1;
            idx_morte     <= '0;
            morte_noite   <= 1'b0;
            timer         <= '0;
            alvo_pend     <= '0;
            alvo_voto     <= '0;
            pend_valido   <= 1'b0;
            lobos         <= '0;
        end else begin
            case (estado)
                INICIAL:       if (jogar) estado <= RESETA;
                RESETA: begin
                    estado        <= PREPARA_JOGO;
                    jogador_atual <= '0;
                    vivos         <= '1;
                    idx_morte     <= '0;
                    morte_noite   <= 1'b0;
                    pend_valido   <= 1'b0;
                end
                PREPARA_JOGO:  if (passa) estado <= ARMAZENA;
                ARMAZENA: begin
                    lobos  <= lobo_mask;
                    estado <= PREPARA_NOITE;
                end
                PREPARA_NOITE: begin
                    jogador_atual <= '0;
                    pend_valido   <= 1'b0;
                    estado        <= CHECAR_VIVO;
                end
                CHECAR_VIVO:   estado <= vivos_x[jogador_atual] ? DELAY_NOITE : ultimo ? FIM_NOITE : PROXIMO;
                DELAY_NOITE:   if (passa) estado <= TURNO_NOITE;
                TURNO_NOITE: if (passa && jogou) begin
                    if (lobos_x[jogador_atual]) begin
                        alvo_pend   <= alvo;
                        pend_valido <= 1'b1;
                    end
                    estado <= ultimo ? FIM_NOITE : PROXIMO;
                end
                PROXIMO: begin
                    if (!ultimo) jogador_atual <= jogador_atual + 1'b1;
                    estado <= CHECAR_VIVO;
                end
                FIM_NOITE: begin
                    morte_noite <= mata;
                    if (mata) begin
                        vivos     <= vivos & ~um_pend[N_JOG-1:0];
                        idx_morte <= alvo_pend;
                    end
                    estado <= ANUNCIAR;
                end
                ANUNCIAR: if (passa) begin
                    morte_noite <= 1'b0;
                    estado      <= CHECA_NOITE;
                end
                CHECA_NOITE: begin
                    timer  <= W_T'(T_DISC - 1);
                    estado <= lobo_perdeu ? LOBO_PERDEU : lobo_ganhou ? LOBO_GANHOU : DIA_DISCUSSAO;
                end
                DIA_DISCUSSAO: if (passa || timer == '0) estado <= DIA_VOTO; else timer <= timer - 1'b1;
                DIA_VOTO: if (passa && votou && vivos_x[alvo]) begin
                    alvo_voto <= alvo;
                    estado    <= PROCESSA_VOTO;
                end
                PROCESSA_VOTO: begin
                    vivos     <= vivos & ~um_voto[N_JOG-1:0];
                    idx_morte <= alvo_voto;
                    estado    <= CHECA_DIA;
                end
                CHECA_DIA:     estado <= lobo_perdeu ? LOBO_PERDEU : lobo_ganhou ? LOBO_GANHOU : PREPARA_NOITE;
                LOBO_GANHOU,
                LOBO_PERDEU:   if (jogar) estado <= RESETA;
                default:       estado <= INICIAL;
            endcase
        end
    end

    assign mostra_classe = estado == TURNO_NOITE;
    assign voto          = estado == DIA_VOTO;
    assign inc_seed      = estado == PREPARA_JOGO;
    assign e_seed_reg    = estado == ARMAZENA;
    assign rst_global    = estado == INICIAL || estado == RESETA;
    assign db_estado     = estado > LOBO_PERDEU ? DB_ERRO : estado;
endmodule

// File: tb/tb_controle_partida.sv
// tb_controle_partida: directed checks of the game FSM on a 5-player and a 3-player instance.
module tb_controle_partida;
    logic       clock = 1'b0;
    logic       reset, reset_b, jogar, passa, jogou, votou;
    logic [4:0] lobo_mask;
    logic [3:0] alvo;
    int         total = 0, bad = 0;

    logic [3:0] a_jog, a_idx;
    logic [4:0] a_vivos, a_db;
    logic       a_morte, a_mostra, a_voto, a_inc, a_eseed, a_rstg;
    logic [1:0] b_jog, b_idx;
    logic [2:0] b_vivos;
    logic [4:0] b_db;
    logic       b_morte, b_mostra, b_voto, b_inc, b_eseed, b_rstg;

    always #5 clock = ~clock;

    controle_partida #(.N_JOG(5), .W_IDX(4), .T_DISC(10)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .passa(passa), .jogou(jogou), .votou(votou),
        .lobo_mask(lobo_mask), .alvo(alvo), .jogador_atual(a_jog), .vivos(a_vivos),
        .morte_noite(a_morte), .idx_morte(a_idx), .mostra_classe(a_mostra), .voto(a_voto),
        .inc_seed(a_inc), .e_seed_reg(a_eseed), .rst_global(a_rstg), .db_estado(a_db)
    );

    controle_partida #(.N_JOG(3), .W_IDX(2), .T_DISC(10)) dut_b (
        .clock(clock), .reset(reset_b), .jogar(jogar), .passa(passa), .jogou(jogou), .votou(votou),
        .lobo_mask(lobo_mask[2:0]), .alvo(alvo[1:0]), .jogador_atual(b_jog), .vivos(b_vivos),
        .morte_noite(b_morte), .idx_morte(b_idx), .mostra_classe(b_mostra), .voto(b_voto),
        .inc_seed(b_inc), .e_seed_reg(b_eseed), .rst_global(b_rstg), .db_estado(b_db)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From CHECAR_VIVO with a live player: play one night turn aiming at a.
    task automatic turno(input logic [3:0] a);
        tick;
        passa = 1'b1;
        tick;
        jogou = 1'b1;
        alvo  = a;
        tick;
        passa = 1'b0;
        jogou = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reset_b = 1'b1;
        jogar = 1'b0; passa = 1'b0; jogou = 1'b0; votou = 1'b0;
        lobo_mask = 5'b00001; alvo = '0;
        tick; tick;
        chk("rst_estado", a_db, 0);
        chk("rst_vivos", a_vivos, 5'b11111);
        chk("rst_jog", a_jog, 0);
        chk("rst_global", a_rstg, 1);
        chk("rst_morte", a_morte, 0);
        reset = 1'b0;
        jogar = 1'b1; tick; jogar = 1'b0;
        chk("reseta", a_db, 1);
        tick;
        chk("prep_jogo", a_db, 2);
        chk("inc_seed", a_inc, 1);
        passa = 1'b1; tick; passa = 1'b0;
        chk("armazena", a_db, 3);
        chk("e_seed_reg", a_eseed, 1);
        tick; chk("prep_noite", a_db, 4);
        tick; chk("checar_vivo", a_db, 5);
        // night 1: wolf 0 aims at 3, villagers aim at 0 (ignored)
        turno(4'd3);
        chk("proximo", a_db, 8);
        tick; chk("jog1", a_jog, 1);
        turno(4'd0); tick;
        turno(4'd0); tick;
        turno(4'd0); tick;
        chk("jog4", a_jog, 4);
        turno(4'd0);
        chk("fim_noite", a_db, 9);
        tick;
        chk("anunciar", a_db, 10);
        chk("n1_vivos", a_vivos, 5'b10111);
        chk("n1_idx", a_idx, 3);
        chk("n1_morte", a_morte, 1);
        passa = 1'b1; tick; passa = 1'b0;
        chk("checa_noite", a_db, 11);
        tick;
        chk("discussao", a_db, 12);
        for (int i = 0; i < 9; i++) tick;
        chk("disc_9cyc", a_db, 12);
        tick;
        chk("disc_timeout", a_db, 13);
        chk("voto_out", a_voto, 1);
        passa = 1'b1; votou = 1'b1; alvo = 4'd3; tick;
        chk("voto_morto", a_db, 13);
        alvo = 4'd7; tick;
        chk("voto_fora", a_db, 13);
        alvo = 4'd1; tick; passa = 1'b0; votou = 1'b0;
        chk("processa", a_db, 14);
        tick;
        chk("checa_dia", a_db, 15);
        chk("d1_vivos", a_vivos, 5'b10101);
        chk("d1_idx", a_idx, 1);
        tick; chk("dia_noite", a_db, 4);
        chk("morte_limpa", a_morte, 0);
        tick;
        // night 2: wolf aims at dead player 3
        turno(4'd3);
        tick; chk("morto_jog1", a_jog, 1);
        tick; chk("pula_morto", a_db, 8);
        tick; turno(4'd0);
        tick; tick; tick;
        chk("jog4_n2", a_jog, 4);
        turno(4'd0);
        tick;
        chk("n2_anunciar", a_db, 10);
        chk("n2_vivos", a_vivos, 5'b10101);
        chk("n2_morte", a_morte, 0);
        chk("n2_idx", a_idx, 1);
        passa = 1'b1; tick; passa = 1'b0;
        tick; chk("n2_disc", a_db, 12);
        passa = 1'b1; tick;
        chk("disc_passa", a_db, 13);
        votou = 1'b1; alvo = 4'd0; tick; passa = 1'b0; votou = 1'b0;
        tick;
        chk("voto_lobo_vivos", a_vivos, 5'b10100);
        chk("voto_lobo_idx", a_idx, 0);
        tick; chk("lobo_perdeu", a_db, 17);
        tick; chk("perdeu_hold", a_db, 17);
        jogar = 1'b1; tick; jogar = 1'b0;
        chk("rejoga", a_db, 1);
        tick;
        chk("rejoga_vivos", a_vivos, 5'b11111);
        chk("rejoga_idx", a_idx, 0);
        passa = 1'b1; tick; passa = 1'b0;
        tick; tick;
        // night 3: wolf aims at itself
        turno(4'd0); tick;
        turno(4'd0); tick;
        turno(4'd0); tick;
        turno(4'd0); tick;
        turno(4'd0); tick;
        chk("auto_db", a_db, 10);
        chk("auto_vivos", a_vivos, 5'b11111);
        chk("auto_morte", a_morte, 0);
        passa = 1'b1; tick; passa = 1'b0;
        tick; passa = 1'b1; tick;
        votou = 1'b1; alvo = 4'd2; tick; passa = 1'b0; votou = 1'b0;
        tick; tick; tick;
        chk("n4_checar", a_db, 5);
        turno(4'd0); tick; tick;
        passa = 1'b1; tick; passa = 1'b0;
        chk("turno_noite", a_db, 7);
        chk("mostra_classe", a_mostra, 1);
        chk("turno_jog", a_jog, 1);
        chk("turno_vivos", a_vivos, 5'b11011);
        #2 reset = 1'b1;
        #1;
        chk("async_db", a_db, 0);
        chk("async_vivos", a_vivos, 5'b11111);
        chk("async_jog", a_jog, 0);
        // 3-player instance: one wolf kills one of two villagers
        reset_b = 1'b0;
        tick;
        jogar = 1'b1; tick; jogar = 1'b0;
        tick;
        passa = 1'b1; tick; passa = 1'b0;
        tick; tick;
        chk("b_checar", b_db, 5);
        turno(4'd2); tick;
        turno(4'd0); tick;
        turno(4'd0);
        tick;
        chk("b_anunciar", b_db, 10);
        chk("b_vivos", b_vivos, 3'b011);
        chk("b_idx", b_idx, 2);
        chk("b_morte", b_morte, 1);
        passa = 1'b1; tick; passa = 1'b0;
        chk("b_checa", b_db, 11);
        tick;
        chk("b_ganhou", b_db, 16);
        tick;
        chk("b_ganhou_hold", b_db, 16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
